count_sequencer: RTL and testbench

//  Synchronous controller for the 4-bit counter datapath: loads a start value, steps the

---
 rtl/count_pkg.sv | 20 ++
 rtl/count_sequencer_if.sv | 32 +++
 rtl/count_prescaler.sv | 29 ++
 rtl/count_sequencer.sv | 93 +++++++++
 tb/tb_count_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the count sequencer: state encoding and default widths.
package count_pkg;

    localparam int STATE_W = 3;
    localparam int DEF_W   = 4;
    localparam int DEF_PW  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/count_sequencer_if.sv
// Control, configuration and status bundle between the control logic and the count sequencer.
interface count_sequencer_if
    import count_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int PW = DEF_PW
) ();

    logic          start;
    logic          stop;
    logic          pause;
    logic          auto_rld;
    logic          dir_up;
    logic [PW-1:0] prescale;
    logic [W-1:0]  load_val;
    logic [W-1:0]  term_val;
    logic [W-1:0]  count;
    logic          busy;
    logic          tc_pulse;
    logic          done;

    modport master (
        output start, stop, pause, auto_rld, dir_up, prescale, load_val, term_val,
        input  count, busy, tc_pulse, done
    );

    modport slave (
        input  start, stop, pause, auto_rld, dir_up, prescale, load_val, term_val,
        output count, busy, tc_pulse, done
    );

endinterface

// File: rtl/count_prescaler.sv
// Rate divider: raises tick every prescale+1 enabled cycles; owns the prescale counter pc.
module count_prescaler #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic [PW-1:0] prescale,
    output logic          tick
);

    logic [PW-1:0] pc;

    // prescale is live, so a value below pc is only matched after pc wraps naturally
    assign tick = (pc == prescale);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (en) begin
            pc <= tick ? '0 : pc + 1'b1;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Sequenced up/down counter with prescaled stepping, terminal-count detection,
// one-shot or auto-reload operation, and pause/resume/abort control.
module count_sequencer
    import count_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int PW = DEF_PW
) (
    input  logic            clk,
    input  logic            rst_n,
    count_sequencer_if.slave bus
);

    state_t         state, state_nxt;
    logic [W-1:0]   count_q, count_nxt;
    logic           tc_q, tc_nxt;
    logic           busy_q, done_q;
    logic           tick;
    logic           pre_en, pre_clr;

    // The prescaler only advances while actually running; a paused RUN cycle keeps its phase.
    assign pre_en  = (state == ST_RUN) && !bus.pause;
    assign pre_clr = (state == ST_LOAD);

    count_prescaler #(.PW(PW)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (pre_en),
        .clr      (pre_clr),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        count_nxt = count_q;
        tc_nxt    = 1'b0;

        if (bus.stop) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) state_nxt = ST_LOAD;
                end
                ST_LOAD: begin
                    state_nxt = ST_RUN;
                    count_nxt = bus.load_val;
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_nxt = ST_HOLD;
                    end else if (tick) begin
                        if (count_q == bus.term_val) begin
                            tc_nxt = 1'b1;
                            if (bus.auto_rld) count_nxt = bus.load_val;
                            else              state_nxt = ST_DONE;
                        end else begin
                            count_nxt = bus.dir_up ? count_q + W'(1) : count_q - W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!bus.pause) state_nxt = ST_RUN;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            count_q <= count_nxt;
            tc_q    <= tc_nxt;
            busy_q  <= is_busy(state_nxt);
            done_q  <= (state_nxt == ST_DONE);
        end
    end

    assign bus.count    = count_q;
    assign bus.busy     = busy_q;
    assign bus.tc_pulse = tc_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Randomized and directed bench for count_sequencer against an arithmetic reference model.
module tb_count_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    count_sequencer_if #(.W(4), .PW(8)) bus ();

    count_sequencer #(.W(4), .PW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: progress is measured in effective run edges (m_e); ticks and
    // terminal counts follow from division by the prescale period and the sequence length.
    bit       m_busy, m_loaded, m_hold, m_done, m_tc;
    logic [3:0] m_count;
    int       m_e;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_loaded = 0; m_hold = 0; m_done = 0; m_tc = 0;
        m_count = 4'd0; m_e = 0;
    endtask

    task automatic model_edge();
        int p, d, n, k;
        p = int'(bus.prescale);
        d = bus.dir_up ? int'(4'(bus.term_val - bus.load_val))
                       : int'(4'(bus.load_val - bus.term_val));
        m_tc = 0;
        if (bus.stop) begin
            m_busy = 0;
            m_done = 0;
        end else if (!m_busy) begin
            if (bus.start) begin
                m_busy = 1; m_loaded = 0; m_done = 0;
            end
        end else if (!m_loaded) begin
            m_loaded = 1; m_count = bus.load_val; m_e = 0; m_hold = 0;
        end else if (bus.pause) begin
            m_hold = 1;
        end else if (m_hold) begin
            m_hold = 0;
        end else begin
            m_e++;
            if (m_e % (p + 1) == 0) begin
                n = m_e / (p + 1);
                k = n % (d + 1);
                if (k == 0) begin
                    m_tc = 1;
                    if (bus.auto_rld) m_count = bus.load_val;
                    else begin m_busy = 0; m_done = 1; end
                end else begin
                    m_count = bus.dir_up ? 4'(bus.load_val + 4'(k)) : 4'(bus.load_val - 4'(k));
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".count"}, 32'(bus.count),    32'(m_count));
        check({tag, ".busy"},  32'(bus.busy),     32'(m_busy));
        check({tag, ".done"},  32'(bus.done),     32'(m_done));
        check({tag, ".tc"},    32'(bus.tc_pulse), 32'(m_tc));
    endtask

    task automatic tick_cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic set_cfg(input bit dir, input bit arl, input logic [3:0] ld,
                           input logic [3:0] tv, input logic [7:0] ps);
        bus.dir_up = dir; bus.auto_rld = arl; bus.load_val = ld;
        bus.term_val = tv; bus.prescale = ps;
    endtask

    task automatic run_seq(input string tag, input bit dir, input bit arl,
                           input logic [3:0] ld, input logic [3:0] tv, input logic [7:0] ps,
                           input int cycles, input int pause_pct, input int start_pct,
                           input bit stop_with_start);
        set_cfg(dir, arl, ld, tv, ps);
        bus.start = 1'b1;
        tick_cycle(tag);
        bus.start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            bus.pause = ($urandom_range(99) < 32'(pause_pct));
            bus.start = ($urandom_range(99) < 32'(start_pct));
            tick_cycle(tag);
        end
        bus.pause = 1'b0;
        bus.stop  = 1'b1;
        bus.start = stop_with_start;
        tick_cycle({tag, ".stop"});
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        tick_cycle({tag, ".idle"});
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.pause = 0;
        set_cfg(1'b1, 1'b0, 4'd0, 4'd0, 8'd0);
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_outputs("reset");
        #8 rst_n = 1'b1;

        // Asynchronous reset while running at count 5
        set_cfg(1'b1, 1'b0, 4'd0, 4'd9, 8'd0);
        bus.start = 1'b1;
        tick_cycle("rst_run");
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !(m_loaded && m_count == 4'd5); i++) tick_cycle("rst_run");
        check("rst_run.reached5", 32'(bus.count), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        #2 rst_n = 1'b1;
        tick_cycle("rst_after");

        run_seq("oneshot_up",  1'b1, 1'b0, 4'd0,  4'd3,  8'd0, 8,  0, 0, 1'b0);
        run_seq("auto_down",   1'b0, 1'b1, 4'd2,  4'd0,  8'd0, 14, 0, 0, 1'b0);
        run_seq("wrap_up",     1'b1, 1'b0, 4'd14, 4'd1,  8'd0, 8,  0, 0, 1'b0);
        run_seq("wrap_down",   1'b0, 1'b0, 4'd1,  4'd14, 8'd0, 8,  0, 0, 1'b0);
        run_seq("ld_eq_term",  1'b1, 1'b1, 4'd7,  4'd7,  8'd2, 12, 0, 0, 1'b0);
        run_seq("start_busy",  1'b1, 1'b1, 4'd3,  4'd9,  8'd1, 30, 0, 50, 1'b1);

        // Prescale 3 with a 10-cycle pause in the middle of the run
        set_cfg(1'b1, 1'b1, 4'd0, 4'd15, 8'd3);
        bus.start = 1'b1;
        tick_cycle("pause");
        bus.start = 1'b0;
        repeat (9)  tick_cycle("pause.pre");
        bus.pause = 1'b1;
        repeat (10) tick_cycle("pause.hold");
        bus.pause = 1'b0;
        repeat (20) tick_cycle("pause.post");
        bus.stop = 1'b1;
        tick_cycle("pause.stop");
        bus.stop = 1'b0;

        // Restart from DONE: done must fall on the LOAD edge
        set_cfg(1'b1, 1'b0, 4'd5, 4'd6, 8'd0);
        bus.start = 1'b1;
        tick_cycle("redo");
        bus.start = 1'b0;
        repeat (5) tick_cycle("redo.run");
        check("redo.in_done", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        tick_cycle("redo.load");
        bus.start = 1'b0;
        repeat (5) tick_cycle("redo.run2");
        bus.stop = 1'b1;
        tick_cycle("redo.stop");
        bus.stop = 1'b0;

        for (int r = 0; r < 40; r++) begin
            run_seq("rand", 1'($urandom_range(1)), 1'($urandom_range(1)),
                    4'($urandom_range(15)), 4'($urandom_range(15)), 8'($urandom_range(3)),
                    int'($urandom_range(80, 20)), int'($urandom_range(30)),
                    int'($urandom_range(10)), 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
